// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF instruction, detects load-use hazards,
// and holds the ID/EX register presented to EX one cycle after accept.
module id_stage #(
  parameter logic [31:0] RESET_VEC_ID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] PC_IF,
  input  logic [31:0] IR_IF,
  input  logic [1:0]  imem_axi_rresp_IF,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        load_EX,
  input  logic [4:0]  rd_EX,
  input  logic        jump_mpred_EX,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] PC_ID,
  output logic [31:0] IR_ID,
  output logic [31:0] imm_ID,
  output logic [31:0] rs1_data_ID,
  output logic [31:0] rs2_data_ID,
  output logic [4:0]  rd_ID,
  output logic [3:0]  alu_op_ID,
  output logic [1:0]  src1_sel_ID,
  output logic        src2_sel_ID,
  output logic        mem_rd_ID,
  output logic        mem_wr_ID,
  output logic [2:0]  mem_size_ID,
  output logic        branch_ID,
  output logic        jump_ID,
  output logic [2:0]  br_cond_ID,
  output logic        exc_ID,
  output logic [3:0]  exc_cause_ID
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic        branch;
    logic        jump;
    logic [2:0]  br_cond;
    logic        exc;
    logic [3:0]  exc_cause;
  } idex_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal, is_ecall, is_ebreak;
  logic        rs1_used, rs2_used;
  logic        hazard, accept;
  idex_t       dec;
  idex_t       payload_d, payload_q;
  logic        valid_d, valid_q;

  assign opcode   = IR_IF[6:0];
  assign funct3   = IR_IF[14:12];
  assign funct7   = IR_IF[31:25];
  assign rs1_addr = IR_IF[19:15];
  assign rs2_addr = IR_IF[24:20];

  assign imm_i = {{20{IR_IF[31]}}, IR_IF[31:20]};
  assign imm_s = {{20{IR_IF[31]}}, IR_IF[31:25], IR_IF[11:7]};
  assign imm_b = {{19{IR_IF[31]}}, IR_IF[31], IR_IF[7], IR_IF[30:25], IR_IF[11:8], 1'b0};
  assign imm_u = {IR_IF[31:12], 12'b0};
  assign imm_j = {{11{IR_IF[31]}}, IR_IF[31], IR_IF[19:12], IR_IF[20], IR_IF[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    illegal   = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    dec.pc       = PC_IF;
    dec.ir       = IR_IF;
    dec.rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    dec.rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;
    case (opcode)
      OPC_LUI: begin
        dec.rd = IR_IF[11:7]; dec.imm = imm_u; dec.src1_sel = 2'd2; dec.src2_sel = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = IR_IF[11:7]; dec.imm = imm_u; dec.src1_sel = 2'd1; dec.src2_sel = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = IR_IF[11:7]; dec.imm = imm_j; dec.src1_sel = 2'd1; dec.src2_sel = 1'b1;
        dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.rd = IR_IF[11:7]; dec.imm = imm_i; dec.src2_sel = 1'b1; dec.jump = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1; dec.br_cond = funct3;
        rs1_used = 1'b1; rs2_used = 1'b1;
        illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.rd = IR_IF[11:7]; dec.imm = imm_i; dec.src2_sel = 1'b1;
        dec.mem_rd = 1'b1; dec.mem_size = funct3; rs1_used = 1'b1;
        illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.src2_sel = 1'b1; dec.mem_wr = 1'b1; dec.mem_size = funct3;
        rs1_used = 1'b1; rs2_used = 1'b1;
        illegal = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        // only the shift-right immediate carries the arithmetic bit in IR[30]
        dec.rd = IR_IF[11:7]; dec.imm = imm_i; dec.src2_sel = 1'b1;
        dec.alu_op = {(funct3 == 3'b101) & IR_IF[30], funct3};
        rs1_used = 1'b1;
      end
      OPC_OP: begin
        dec.rd = IR_IF[11:7]; dec.alu_op = {IR_IF[30], funct3};
        rs1_used = 1'b1; rs2_used = 1'b1;
        illegal = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (IR_IF == 32'h0000_0073)      is_ecall  = 1'b1;
        else if (IR_IF == 32'h0010_0073) is_ebreak = 1'b1;
        else                             illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (imem_axi_rresp_IF != 2'b00) begin
      dec.exc = 1'b1; dec.exc_cause = 4'd1;
    end else if (illegal) begin
      dec.exc = 1'b1; dec.exc_cause = 4'd2;
    end else if (is_ebreak) begin
      dec.exc = 1'b1; dec.exc_cause = 4'd3;
    end else if (is_ecall) begin
      dec.exc = 1'b1; dec.exc_cause = 4'd11;
    end
    if (dec.exc) begin
      dec.rd = 5'd0; dec.mem_rd = 1'b0; dec.mem_wr = 1'b0;
      dec.branch = 1'b0; dec.jump = 1'b0;
    end
  end

  assign hazard = valid_in && load_EX && (rd_EX != 5'd0) &&
                  ((rs1_used && (rd_EX == rs1_addr)) || (rs2_used && (rd_EX == rs2_addr)));
  assign ready_out = (!valid_q || ready_in) && !hazard;
  assign accept    = valid_in && ready_out;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (jump_mpred_EX) begin
      valid_d   = 1'b0;
      payload_d = '0;
    end else if (accept) begin
      valid_d   = 1'b1;
      payload_d = dec;
    end else if (valid_q && ready_in) begin
      valid_d   = 1'b0;
      payload_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= 1'b0;
      payload_q      <= '0;
      payload_q.pc   <= RESET_VEC_ID;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_out    = valid_q && !jump_mpred_EX;
  assign PC_ID        = payload_q.pc;
  assign IR_ID        = payload_q.ir;
  assign imm_ID       = payload_q.imm;
  assign rs1_data_ID  = payload_q.rs1_data;
  assign rs2_data_ID  = payload_q.rs2_data;
  assign rd_ID        = payload_q.rd;
  assign alu_op_ID    = payload_q.alu_op;
  assign src1_sel_ID  = payload_q.src1_sel;
  assign src2_sel_ID  = payload_q.src2_sel;
  assign mem_rd_ID    = payload_q.mem_rd;
  assign mem_wr_ID    = payload_q.mem_wr;
  assign mem_size_ID  = payload_q.mem_size;
  assign branch_ID    = payload_q.branch;
  assign jump_ID      = payload_q.jump;
  assign br_cond_ID   = payload_q.br_cond;
  assign exc_ID       = payload_q.exc;
  assign exc_cause_ID = payload_q.exc_cause;

endmodule
